// File: rtl/adc_capture_sequencer_if.sv
// adc_capture_sequencer_if: host request, ADC input, FIFO flow control and capture outputs
interface adc_capture_sequencer_if;
   logic        collectData;
   logic        testMode;
   logic [9:0]  adcData;
   logic        fifoFull;
   logic [9:0]  dataOut;
   logic        dataValid;
   logic        overflow;
   logic        busy;
   logic [31:0] sampleCount;
   modport slave (input collectData, testMode, adcData, fifoFull,
                  output dataOut, dataValid, overflow, busy, sampleCount);
   modport master (output collectData, testMode, adcData, fifoFull,
                   input dataOut, dataValid, overflow, busy, sampleCount);
endinterface

// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer: arms/stops ADC capture, drops settling samples, muxes ADC or test ramp into the FIFO
module adc_capture_sequencer #(
   parameter int unsigned DISCARD_COUNT = 4,
   parameter int unsigned TEST_MAX = 1020
) (
   input logic inclk,
   input logic reset,
   adc_capture_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HALT} state_t;
   state_t state;
   logic [1:0] sync;
   logic collect_sync;
   logic mode;
   logic [7:0] discard;
   logic [9:0] ramp;
   assign collect_sync = sync[1];
   always_ff @(posedge inclk) begin
      if (reset) begin
         state <= IDLE;
         sync <= '0;
         mode <= 1'b0;
         discard <= '0;
         ramp <= '0;
         bus.dataOut <= '0;
         bus.dataValid <= 1'b0;
         bus.overflow <= 1'b0;
         bus.busy <= 1'b0;
         bus.sampleCount <= '0;
      end else begin
         sync <= {sync[0], bus.collectData};
         bus.dataValid <= 1'b0;
         case (state)
            IDLE: if (collect_sync) begin
               state <= SETTLE;
               bus.busy <= 1'b1;
               mode <= bus.testMode;
               bus.sampleCount <= '0;
               bus.overflow <= 1'b0;
               discard <= '0;
               ramp <= '0;
            end
            SETTLE: if (!collect_sync) begin
               state <= IDLE;
               bus.busy <= 1'b0;
            end else if (discard == 8'(DISCARD_COUNT - 1)) begin
               state <= CAPTURE;
            end else begin
               discard <= discard + 8'd1;
            end
            CAPTURE: if (!collect_sync) begin
               state <= IDLE;
               bus.busy <= 1'b0;
            end else if (bus.fifoFull) begin
               // the word presented this cycle is already committed; stop before the next one
               state <= HALT;
               bus.overflow <= 1'b1;
            end else begin
               bus.dataValid <= 1'b1;
               bus.dataOut <= mode ? ramp : bus.adcData;
               bus.sampleCount <= &bus.sampleCount ? bus.sampleCount : bus.sampleCount + 32'd1;
               ramp <= (ramp == 10'(TEST_MAX)) ? 10'd0 : ramp + 10'd1;
            end
            HALT: if (!collect_sync) begin
               state <= IDLE;
               bus.busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_adc_capture_sequencer.sv
// tb_adc_capture_sequencer: directed capture scenarios with immediate-assertion checks
module tb_adc_capture_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   adc_capture_sequencer_if bus();
   adc_capture_sequencer #(.DISCARD_COUNT(4), .TEST_MAX(1020)) dut (.inclk(clk), .reset(rst), .bus(bus));
   int tests = 0;
   int failed = 0;
   int nwords = 0;
   int cyc = 0;
   int g;
   logic [9:0] prev_adc, ramp_m, last_word, w1020, w1021;
   logic tmode = 1'b0;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic tick;
      prev_adc = bus.adcData;
      @(posedge clk);
      #1;
      cyc++;
      bus.adcData = 10'(cyc);
      if (bus.dataValid === 1'b1) begin
         nwords++;
         chk("word", 32'(bus.dataOut), 32'(tmode ? ramp_m : prev_adc));
         if (nwords == 1021) w1020 = bus.dataOut;
         if (nwords == 1022) w1021 = bus.dataOut;
         last_word = bus.dataOut;
         ramp_m = (ramp_m == 10'd1020) ? 10'd0 : ramp_m + 10'd1;
      end
   endtask
   task automatic start(input logic tm);
      bus.testMode = tm;
      tmode = tm;
      ramp_m = '0;
      nwords = 0;
      bus.collectData = 1'b1;
      tick;
      tick;
      chk("busy_edge2", 32'(bus.busy), 32'd0);
      tick;
      chk("busy_edge3", 32'(bus.busy), 32'd1);
      repeat (4) tick;
      chk("settle_no_dv", 32'(bus.dataValid), 32'd0);
      chk("settle_no_words", 32'(nwords), 32'd0);
      tick;
      chk("first_dv", 32'(bus.dataValid), 32'd1);
   endtask
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
   initial begin
      bus.collectData = 1'b0;
      bus.testMode = 1'b0;
      bus.adcData = '0;
      bus.fifoFull = 1'b0;
      tick;
      tick;
      chk("rst_dataOut", 32'(bus.dataOut), 32'd0);
      chk("rst_dataValid", 32'(bus.dataValid), 32'd0);
      chk("rst_overflow", 32'(bus.overflow), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_count", bus.sampleCount, 32'd0);
      rst = 1'b0;
      tick;
      chk("idle_busy", 32'(bus.busy), 32'd0);
      // live capture: collectData high 20 cycles, 15 words expected
      start(1'b0);
      repeat (12) tick;
      bus.collectData = 1'b0;
      tick;
      tick;
      chk("live_tail_dv", 32'(bus.dataValid), 32'd1);
      tick;
      chk("live_stop_dv", 32'(bus.dataValid), 32'd0);
      chk("live_stop_busy", 32'(bus.busy), 32'd0);
      chk("live_words", 32'(nwords), 32'd15);
      chk("live_count", bus.sampleCount, 32'd15);
      repeat (3) tick;
      chk("live_idle_dv", 32'(bus.dataValid), 32'd0);
      // test ramp wrap with a mid-capture mode change
      start(1'b1);
      bus.testMode = 1'b0;
      g = 0;
      while (nwords < 1028 && g < 1100) begin
         tick;
         g++;
      end
      bus.collectData = 1'b0;
      repeat (3) tick;
      chk("ramp_words", 32'(nwords), 32'd1030);
      chk("ramp_count", bus.sampleCount, 32'd1030);
      chk("ramp_top", 32'(w1020), 32'd1020);
      chk("ramp_wrap", 32'(w1021), 32'd0);
      chk("ramp_last", 32'(last_word), 32'd8);
      chk("ramp_hold", 32'(bus.dataOut), 32'd8);
      repeat (2) tick;
      // overflow halt, sticky through IDLE, cleared on restart
      start(1'b0);
      g = 0;
      while (nwords < 10 && g < 50) begin
         tick;
         g++;
      end
      chk("ovf_prefill", 32'(nwords), 32'd10);
      bus.fifoFull = 1'b1;
      repeat (3) tick;
      chk("ovf_extra_words", 32'(nwords <= 11), 32'd1);
      chk("ovf_flag", 32'(bus.overflow), 32'd1);
      chk("ovf_dv", 32'(bus.dataValid), 32'd0);
      chk("ovf_busy", 32'(bus.busy), 32'd1);
      chk("ovf_count", bus.sampleCount, 32'(nwords));
      bus.fifoFull = 1'b0;
      repeat (3) tick;
      chk("halt_no_restart", 32'(bus.dataValid), 32'd0);
      bus.collectData = 1'b0;
      repeat (3) tick;
      chk("ovf_idle_busy", 32'(bus.busy), 32'd0);
      chk("ovf_sticky", 32'(bus.overflow), 32'd1);
      bus.collectData = 1'b1;
      repeat (3) tick;
      chk("rearm_busy", 32'(bus.busy), 32'd1);
      chk("rearm_overflow", 32'(bus.overflow), 32'd0);
      chk("rearm_count", bus.sampleCount, 32'd0);
      // abort during settle
      bus.collectData = 1'b0;
      repeat (3) tick;
      chk("abort_pre_busy", 32'(bus.busy), 32'd0);
      nwords = 0;
      bus.collectData = 1'b1;
      repeat (3) tick;
      bus.collectData = 1'b0;
      chk("abort_busy1", 32'(bus.busy), 32'd1);
      tick;
      tick;
      chk("abort_busy3", 32'(bus.busy), 32'd1);
      tick;
      chk("abort_busy_end", 32'(bus.busy), 32'd0);
      repeat (3) tick;
      chk("abort_words", 32'(nwords), 32'd0);
      chk("abort_count", bus.sampleCount, 32'd0);
      // collectSync falls on the same edge fifoFull is seen
      start(1'b0);
      repeat (3) tick;
      bus.collectData = 1'b0;
      tick;
      tick;
      bus.fifoFull = 1'b1;
      tick;
      chk("simul_busy", 32'(bus.busy), 32'd0);
      chk("simul_overflow", 32'(bus.overflow), 32'd0);
      chk("simul_dv", 32'(bus.dataValid), 32'd0);
      chk("simul_count", bus.sampleCount, 32'(nwords));
      bus.fifoFull = 1'b0;
      repeat (2) tick;
      // reset in the middle of a capture
      start(1'b0);
      repeat (3) tick;
      rst = 1'b1;
      tick;
      chk("mrst_dataOut", 32'(bus.dataOut), 32'd0);
      chk("mrst_dv", 32'(bus.dataValid), 32'd0);
      chk("mrst_overflow", 32'(bus.overflow), 32'd0);
      chk("mrst_busy", 32'(bus.busy), 32'd0);
      chk("mrst_count", bus.sampleCount, 32'd0);
      rst = 1'b0;
      start(1'b0);
      repeat (2) tick;
      chk("restart_count", bus.sampleCount, 32'(nwords));
      chk("restart_words", 32'(nwords), 32'd3);
      bus.collectData = 1'b0;
      repeat (3) tick;
      chk("restart_idle", 32'(bus.busy), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/adc_capture_sequencer.md
# adc_capture_sequencer

Capture controller for the 10-bit ADC sample path. Sits between the ADC input pins and the ten-to-sixteen-bit converter feeding the USB FIFO. It arms and stops capture from the host collect request and discards settling samples. It selects between live ADC data and a test ramp, drives the FIFO write strobe, and halts with a sticky overflow flag when the FIFO cannot accept data.

## Interface
Parameters:
- DISCARD_COUNT, 4, samples dropped after start before writing begins (range 1..255)
- TEST_MAX, 1020, last value of test ramp before wrap to 0 (≤1023)

Ports:
- inclk  in  1  sample clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- collectData  in  1  host capture request, asynchronous to inclk; 2-flop synchronized internally
- testMode  in  1  1 = test ramp, 0 = ADC; sampled only on IDLE→SETTLE
- adcData  in  10  unsigned ADC sample, new value every cycle
- fifoFull  in  1  FIFO almost-full; must assert with ≥2 free entries
- dataOut  out  10  selected sample to converter (registered)
- dataValid  out  1  FIFO write strobe, one word per high cycle (registered)
- overflow  out  1  sticky; FIFO full during capture
- busy  out  1  high in SETTLE, CAPTURE, HALT
- sampleCount  out  32  words written since last start, saturating

## Operation
- collectSync = collectData after two flops; all decisions use collectSync.
- States: IDLE, SETTLE, CAPTURE, HALT.
- IDLE → SETTLE when collectSync=1. On entry:
  - latch testMode into modeReg
  - clear sampleCount, overflow, discard counter and test ramp
- SETTLE: count DISCARD_COUNT cycles with dataValid=0, then → CAPTURE.
  - collectSync=0 at any point → IDLE.
- CAPTURE, checked in priority order:
  - collectSync=0 → IDLE, no write.
  - fifoFull=1 → HALT, overflow←1, no write.
  - Otherwise write one word:
    - dataValid←1
    - dataOut←(modeReg ? ramp : adcData)
    - sampleCount←sampleCount+1, saturating at 0xFFFFFFFF
    - ramp advances
- HALT: dataValid=0, overflow held. collectSync=0 → IDLE. No auto-restart.
- overflow stays set through IDLE; cleared only on next IDLE→SETTLE or reset.
- Test ramp:
  - advances only on written words: 0,1,…,TEST_MAX,0,…
  - ADC input ignored in test mode
  - mode changes mid-capture have no effect
- dataOut holds its last value when dataValid=0.
- busy = (state≠IDLE), registered with state.

## Timing
- Reset: state IDLE; dataOut=0, dataValid=0, overflow=0, busy=0, sampleCount=0, ramp=0, sync flops=0.
- collectData rise to busy high: 3 edges (2 sync + state).
- busy high to first dataValid: DISCARD_COUNT+1 cycles.
- adcData sampled at edge n appears on dataOut with dataValid in cycle n+1. Latency 1; throughput 1 word/cycle.
- fifoFull sampled at edge n suppresses the write registered at edge n. The word already presented in cycle n is still written, hence the 2-entry margin.
- collectData fall to last dataValid: at most 3 cycles. After that dataValid stays 0.
- Simultaneous collectSync=0 and fifoFull=1 in CAPTURE: → IDLE, overflow not set.
- Reset asserted mid-capture: next cycle all outputs at reset values; in-flight word dropped.
- sampleCount at 0xFFFFFFFF: writes continue, count holds.

## Test plan
- Live capture:
  - stimulus: reset; adcData = cycle index mod 1024; collectData high 20 cycles then low
  - response: busy at edge 3; first dataValid after 5 more cycles; each word equals adcData of previous cycle; sampleCount equals dataValid high count; no dataValid 3 cycles after drop
- Test ramp wrap:
  - stimulus: testMode=1, TEST_MAX=1020, fifoFull=0, 1030 writes
  - response: dataOut 0..1020, 0..8; sampleCount=1030
- Overflow:
  - stimulus: fifoFull high after 10 writes
  - response: ≤1 further word; overflow=1; state HALT; dataValid=0 while collectData stays high
  - then: drop and re-raise collectData; overflow clears on SETTLE entry; sampleCount restarts at 0
- Abort in SETTLE:
  - stimulus: collectData pulse of 3 synced cycles
  - response: busy pulses; zero writes; sampleCount=0
- Simultaneous events:
  - stimulus: fifoFull and collectSync=0 on the same edge in CAPTURE
  - response: IDLE, overflow=0
- Reset mid-capture:
  - stimulus: reset during CAPTURE
  - response: all outputs 0 next cycle; capture restarts normally on collectData
